// File: rtl/booth_operand_sequencer.sv
// Operand sequencer in front of a 16x16 signed Booth multiplier: buffers tagged
// operand pairs, issues them one at a time, and returns tagged products or watchdog errors.
module booth_operand_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_start,
    output logic [15:0]      mul_in1,
    output logic [15:0]      mul_in2,
    input  logic [31:0]      mul_out,
    input  logic             mul_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; a
    // producer holding valid keeps its payload stable until that edge.

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int ENTRY_W = 32 + TAG_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [1:0]         r_state;
    logic [TAG_W-1:0]   r_tag;
    logic               r_seen_low;
    logic [WD_W-1:0]    r_wd;

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == S_IDLE) && !w_empty;
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b, in_tag};
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // seen_low guards against a done level still high from the previous multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            mul_in1    <= '0;
            mul_in2    <= '0;
            r_tag      <= '0;
            r_seen_low <= 1'b0;
            r_wd       <= '0;
            res_data   <= '0;
            res_tag    <= '0;
            res_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {mul_in1, mul_in2, r_tag} <= w_head;
                        r_state                   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_seen_low <= 1'b0;
                    r_wd       <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done && r_seen_low) begin
                        res_data <= mul_out;
                        res_tag  <= r_tag;
                        res_err  <= 1'b0;
                        r_state  <= S_RESULT;
                    end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        res_data <= '0;
                        res_tag  <= r_tag;
                        res_err  <= 1'b1;
                        r_state  <= S_RESULT;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                        if (!mul_done) begin
                            r_seen_low <= 1'b1;
                        end
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mul_start = (r_state == S_ISSUE);
    assign res_valid = (r_state == S_RESULT);
    assign busy      = (r_state != S_IDLE) || !w_empty;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Randomized bench for booth_operand_sequencer with a behavioural multiplier,
// an expected-result queue and protocol checks on both streams.
module tb_booth_operand_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;
    localparam int TIMEOUT    = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             mul_start;
    logic [15:0]      mul_in1;
    logic [15:0]      mul_in2;
    logic [31:0]      mul_out;
    logic             mul_done;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;
    logic             busy;
    logic [1:0]       dbg_state;

    booth_operand_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mul_start(mul_start), .mul_in1(mul_in1), .mul_in2(mul_in2),
        .mul_out(mul_out), .mul_done(mul_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_err(res_err), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_starts = 0;

    // 0: done pulse, 1: done level held until after next start, 2: done tied low
    int mode   = 0;
    int lat_lo = 17;
    int lat_hi = 17;
    int rr     = 1;

    logic [4+TAG_W+31:0] exp_q[$];
    logic [31:0]         op_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier with a latency drawn per operation.
    int          m_cnt;
    int          m_lat_used;
    logic        m_done;
    logic [31:0] m_prod;
    always @(posedge clk) begin : mul_model
        int l;
        if (rst) begin
            m_cnt      <= 0;
            m_done     <= 1'b0;
            mul_out    <= '0;
            m_lat_used <= 0;
        end else if (mul_start) begin
            l = $urandom_range(lat_hi, lat_lo);
            m_cnt      <= l;
            m_lat_used <= l;
            m_prod     <= $signed(mul_in1) * $signed(mul_in2);
            if (mode != 1) m_done <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (mode == 1 && m_cnt == m_lat_used) m_done <= 1'b0;
            if (m_cnt == 1) begin
                m_done  <= 1'b1;
                mul_out <= m_prod;
            end
        end else if (mode == 0) begin
            m_done <= 1'b0;
        end
    end
    assign mul_done = (mode == 2) ? 1'b0 : m_done;

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            res_ready = (rr == 0) ? 1'b0 : (rr == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: issue checks, result scoreboard, latency and hold-stability.
    initial begin : monitor
        logic                prev_valid;
        logic                prev_start;
        logic                prev_held;
        logic                inflight;
        logic [4+TAG_W+31:0] held;
        logic [31:0]         o;
        int                  start_cyc;
        prev_valid = 0; prev_start = 0; prev_held = 0; inflight = 0; held = '0; start_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 0; prev_start = 0; prev_held = 0; inflight = 0;
            end else begin
                if (mul_start) begin
                    n_starts++;
                    check_eq("start_width", 64'(prev_start), 0);
                    check_eq("one_inflight", 64'(inflight), 0);
                    inflight  = 1;
                    start_cyc = cyc;
                    if (op_q.size() != 0) begin
                        o = op_q.pop_front();
                        check_eq("mul_operands", {mul_in1, mul_in2}, o);
                    end else begin
                        check_eq("spurious_start", 1, 0);
                    end
                end
                if (prev_held) begin
                    check_eq("hold_valid", 64'(res_valid), 1);
                    check_eq("hold_payload", {4'd0, res_err, res_tag, res_data}, held);
                end
                if (res_valid && !prev_valid) begin
                    check_eq("latency", 64'(cyc - start_cyc),
                             (mode == 2) ? 64'(TIMEOUT + 1) : 64'(m_lat_used + 2));
                end
                if (res_valid && res_ready) begin
                    if (exp_q.size() != 0) begin
                        check_eq("result", {4'd0, res_err, res_tag, res_data}, exp_q.pop_front());
                    end else begin
                        check_eq("unexpected_result", 1, 0);
                    end
                    inflight = 0;
                end
                prev_held  = res_valid && !res_ready;
                held       = {4'd0, res_err, res_tag, res_data};
                prev_valid = res_valid;
                prev_start = mul_start;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t);
        int     n;
        longint p;
        logic   err;
        n        = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_eq("push_timeout", 0, 1);
        end else begin
            p   = longint'($signed(a)) * longint'($signed(b));
            err = (mode == 2);
            op_q.push_back({a, b});
            exp_q.push_back({4'd0, err, t, err ? 32'd0 : p[31:0]});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_eq("drain_timeout", 0, 1);
        wait_cycles(1);
    endtask

    initial begin
        int s0;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 1);
        check_eq("rst_res_valid", 64'(res_valid), 0);
        check_eq("rst_busy", 64'(busy), 0);
        check_eq("rst_mul_start", 64'(mul_start), 0);
        check_eq("rst_mul_in", {mul_in1, mul_in2}, 0);
        check_eq("rst_res", {res_err, res_tag, res_data}, 0);
        wait_cycles(1);

        // Single operation with a 17-cycle multiply.
        mode = 0; lat_lo = 17; lat_hi = 17; rr = 1;
        s0 = n_starts;
        push_op(16'd3, -16'sd4, 4'd1);
        drain();
        check_eq("single_start_count", 64'(n_starts - s0), 1);

        // Most-negative operand corners, back to back.
        push_op(-16'sd32768, -16'sd32768, 4'd2);
        push_op(-16'sd32768, 16'sd5, 4'd3);
        drain();

        // Backpressure: one in flight plus a full FIFO.
        rr = 0; lat_lo = 5; lat_hi = 5;
        wait_cycles(2);
        s0 = n_starts;
        push_op(16'($urandom), 16'($urandom), 4'd4);
        wait_cycles(3);
        for (int i = 5; i <= 8; i++) push_op(16'($urandom), 16'($urandom), 4'(i));
        @(negedge clk);
        check_eq("full_in_ready", 64'(in_ready), 0);
        check_eq("full_busy", 64'(busy), 1);
        wait_cycles(30);
        check_eq("stalled_start_count", 64'(n_starts - s0), 1);
        rr = 1;
        drain();
        check_eq("backpressure_start_count", 64'(n_starts - s0), 5);

        // Watchdog: done never arrives.
        mode = 2;
        push_op(16'd7, 16'd9, 4'd12);
        push_op(16'd11, -16'sd2, 4'd13);
        drain();
        mode = 0;
        wait_cycles(2);

        // Done held high across operations must not complete the next one early.
        mode = 1; lat_lo = 6; lat_hi = 6;
        push_op(16'd1000, -16'sd7, 4'd9);
        push_op(16'd123, 16'd456, 4'd10);
        push_op(-16'sd5, -16'sd5, 4'd11);
        drain();
        mode = 0;
        wait_cycles(2);

        // Reset while waiting with two entries queued.
        lat_lo = 17; lat_hi = 17;
        push_op(16'd21, 16'd2, 4'd1);
        push_op(16'd22, 16'd2, 4'd2);
        push_op(16'd23, 16'd2, 4'd3);
        wait_cycles(5);
        rst = 1'b1;
        exp_q.delete();
        op_q.delete();
        wait_cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_busy", 64'(busy), 0);
        check_eq("post_rst_in_ready", 64'(in_ready), 1);
        for (int i = 0; i < 25; i++) begin
            check_eq("post_rst_no_result", 64'(res_valid), 0);
            @(negedge clk);
        end
        wait_cycles(1);
        push_op(-16'sd300, 16'd77, 4'd14);
        drain();

        // Randomized batches alternating done styles with random backpressure.
        rr = 2;
        for (int batch = 0; batch < 4; batch++) begin
            mode   = batch % 2;
            lat_lo = (mode == 1) ? 3 : 2;
            lat_hi = 20;
            for (int i = 0; i < 10; i++) begin
                push_op(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
                wait_cycles($urandom_range(0, 3));
            end
            drain();
            wait_cycles(2);
        end
        mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
